af_output_drain: RTL

Downstream neighbour of the activation-function array. It snapshots the full `OUTPUT_HEIGHT` x `OUTPUT_WIDTH` activated output tile on the rising edge of `finish`. It then streams the tile one row per beat over a valid/ready interface toward the output memory writer. The activation array drives its outputs to Z whenever `finish` is low, so this block must capture while `finish` is high and hold the tile internally until it is drained.

---
 rtl/af_drain_pkg.sv | 30 +++
 rtl/af_tile_reg.sv | 41 ++++
 rtl/af_output_drain.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/af_drain_pkg.sv
// Shared types and helpers for the activation-array output drain.
// Tile dimensions normally come from sys_defs.svh; the guarded defaults below
// let this slice elaborate on its own when that header is not on the path.
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 4
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 4
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 16
`endif

package af_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_t;

  // Width of the saturating overrun event counter.
  localparam int unsigned OVR_CNT_W = 8;

  // Row-index width; at least one bit even for a single-row tile.
  function automatic int unsigned row_w(input int unsigned h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/af_tile_reg.sv
// Tile storage: H x W elements of DW bits, full parallel load, row read port.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low clear
//   i_load       - capture every element of i_data this cycle
//   i_data       - full tile, element [row][col]
//   i_row_sel    - row to present on o_row_c
//   o_row_c      - selected row, element j at bits [j*DW +: DW]
module af_tile_reg #(
  parameter int unsigned H  = 4,
  parameter int unsigned W  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [DW-1:0]       i_data [H-1:0][W-1:0],
  input  logic [RW-1:0]       i_row_sel,
  output logic [W*DW-1:0]     o_row_c
);

  logic [W-1:0][DW-1:0] r_tile [H];

  // Full-tile capture; held until the next load or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < H; i++) begin
        r_tile[i] <= '0;
      end
    end else if (i_load) begin
      for (int unsigned i = 0; i < H; i++) begin
        for (int unsigned j = 0; j < W; j++) begin
          r_tile[i][j] <= i_data[i][j];
        end
      end
    end
  end

  assign o_row_c = r_tile[i_row_sel];

endmodule

// File: rtl/af_output_drain.sv
// Snapshots the activated output tile on the rising edge of finish and streams
// it one row per beat over a valid/ready interface.
// Optional feature macro: AF_DRAIN_OVERRUN_CNT_EN (adds saturating overrun_cnt).
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   finish          - tile-complete level; AF_outputs valid only while high
//   AF_outputs      - activated tile, element [row][col]
//   out_valid/ready - row beat handshake
//   out_data        - row data, element j at bits [j*DW +: DW]
//   out_row         - row index of the current beat
//   out_last        - current beat is row H-1
//   busy            - a tile is held or being drained
//   done            - one-cycle pulse after the last beat is accepted
//   overrun         - sticky: finish rose while busy
//   overrun_cnt     - (macro only) saturating count of overrun events
module af_output_drain
  import af_drain_pkg::*;
#(
  parameter int unsigned H  = `OUTPUT_HEIGHT,
  parameter int unsigned W  = `OUTPUT_WIDTH,
  parameter int unsigned DW = `OUT_BIN_LEN
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     finish,
  input  logic [DW-1:0]            AF_outputs [H-1:0][W-1:0],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W*DW-1:0]          out_data,
  output logic [row_w(H)-1:0]      out_row,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
`ifdef AF_DRAIN_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0]     overrun_cnt
`endif
);

  localparam int unsigned  RW       = row_w(H);
  localparam logic [RW-1:0] LAST_ROW = RW'(H - 1);

  drain_state_t  r_state;
  logic [RW-1:0] r_row_cnt;
  logic          r_finish_q;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;

  logic          w_start;
  logic          w_load;
  logic          w_accept;
  logic          w_overrun_evt;

  assign w_start       = finish & ~r_finish_q;
  assign w_load        = w_start && (r_state == IDLE);
  assign w_overrun_evt = w_start && (r_state != IDLE);
  assign w_accept      = r_out_valid & out_ready;

  // Tile is captured only from IDLE, so a late edge never corrupts a drain.
  af_tile_reg #(
    .H  (H),
    .W  (W),
    .DW (DW),
    .RW (RW)
  ) u_tile (
    .clk       (clock),
    .rst_n     (reset_n),
    .i_load    (w_load),
    .i_data    (AF_outputs),
    .i_row_sel (r_row_cnt),
    .o_row_c   (out_data)
  );

  // Drain FSM, edge detect and registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_finish_q  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_finish_q <= finish;
      r_done     <= 1'b0;
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= SEND;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (H == 1);
            r_busy      <= 1'b1;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (r_out_last) begin
              r_state     <= DONE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_row_cnt  <= r_row_cnt + RW'(1);
              r_out_last <= ((r_row_cnt + RW'(1)) == LAST_ROW);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_row_cnt;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef AF_DRAIN_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  // Saturating count of finish edges that arrived while busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr_cnt <= '0;
    end else if (w_overrun_evt && (r_ovr_cnt != '1)) begin
      r_ovr_cnt <= r_ovr_cnt + OVR_CNT_W'(1);
    end
  end

  assign overrun_cnt = r_ovr_cnt;
  assign overrun     = (r_ovr_cnt != '0);
`else
  assign overrun = r_overrun;
`endif

endmodule
